metadata_server: RTL and testbench

- Responder end of the metadata request/available handshake used by the scoring block.
- Holds per-channel read pointers into the song-metadata BRAM, which is filled from SD card.
- Arbitrates requests from N_CH consumer channels round-robin, fetches one 16-bit word per grant and places it in that channel's slot of the packed metadata_link bus.
- Sits in the control/loader block, between the BRAM and the scoring block.

---
 rtl/metadata_server_pkg.sv | 26 ++
 rtl/metadata_server_if.sv | 30 +++
 rtl/metadata_server_rr_arbiter.sv | 28 ++
 rtl/metadata_server.sv | 88 ++++++++
 tb/tb_metadata_server.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/metadata_server_pkg.sv
// Shared parameters, FSM encoding and address/slot helpers for the metadata server.
package metadata_server_pkg;
    localparam int N_CH     = 37;
    localparam int DW       = 16;
    localparam int CH_DEPTH = 256;
    localparam int AW       = 14;
    localparam int PW       = $clog2(CH_DEPTH);
    localparam int CW       = $clog2(N_CH);
    localparam int LW       = $clog2(N_CH * DW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    // Channel regions are CH_DEPTH-aligned, so the address is {ch, ptr}.
    function automatic logic [AW-1:0] slot_addr(logic [CW-1:0] ch, logic [PW-1:0] ptr);
        return (AW'(ch) << PW) | AW'(ptr);
    endfunction

    function automatic logic [LW-1:0] slot_lsb(logic [CW-1:0] ch);
        return LW'(ch) * LW'(DW);
    endfunction
endpackage

// File: rtl/metadata_server_if.sv
// Consumer/BRAM bundle of the metadata server; state is exported for debug.
interface metadata_server_if;
    import metadata_server_pkg::*;

    // Handshake: request[i] is a level held by the consumer until available[i]
    // pulses for one cycle; slot i of metadata_link is valid from that pulse
    // until the next delivery to channel i. The consumer drops request[i] the
    // cycle after the pulse or keeps it high to ask for the next word.
    logic                 load_done;
    logic                 pause;
    logic                 rewind;
    logic [N_CH-1:0]      metadata_request;
    logic [DW-1:0]        mem_rdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_rd_en;
    logic [N_CH*DW-1:0]   metadata_link;
    logic [N_CH-1:0]      metadata_available;
    logic                 busy;
    state_e               state;

    modport slave (
        input  load_done, pause, rewind, metadata_request, mem_rdata,
        output mem_addr, mem_rd_en, metadata_link, metadata_available, busy, state
    );

    modport master (
        output load_done, pause, rewind, metadata_request, mem_rdata,
        input  mem_addr, mem_rd_en, metadata_link, metadata_available, busy, state
    );
endinterface

// File: rtl/metadata_server_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_i, wrapping N_CH-1 -> 0.
module metadata_server_rr_arbiter
    import metadata_server_pkg::*;
(
    input  logic [N_CH-1:0] req_i,
    input  logic [CW-1:0]   rr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [CW-1:0]   idx_o,
    output logic            valid_o
);
    logic [CW:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_i} + (CW+1)'(k);
            if (cand >= (CW+1)'(N_CH)) cand = cand - (CW+1)'(N_CH);
            if (!valid_o && req_i[cand[CW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[CW-1:0];
            end
        end
        if (valid_o) gnt_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/metadata_server.sv
// Serves one BRAM word per grant to N_CH channels, keeping a read pointer per channel.
module metadata_server
    import metadata_server_pkg::*;
(
    input logic          clk,
    input logic          reset,
    metadata_server_if.slave bus
);
    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q [N_CH];
    logic [CW-1:0]      rr_q, ch_q, arb_idx;
    logic [N_CH-1:0]    gnt_q, avail_q, arb_gnt, eligible;
    logic [AW-1:0]      addr_q;
    logic [N_CH*DW-1:0] link_q;
    logic               arb_valid, go, rewound_q;

    // A channel whose pulse is high this cycle is masked so it cannot be re-granted.
    assign eligible = bus.metadata_request & ~avail_q;
    assign go       = bus.load_done & ~bus.pause & arb_valid;

    metadata_server_rr_arbiter u_arb (
        .req_i   (eligible),
        .rr_i    (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_GRANT;
            ST_GRANT:   state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_DELIVER;
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) ptr_q[i] <= '0;
            rr_q      <= '0;
            ch_q      <= '0;
            gnt_q     <= '0;
            avail_q   <= '0;
            addr_q    <= '0;
            link_q    <= '0;
            rewound_q <= 1'b0;
        end else begin
            avail_q <= '0;
            case (state_q)
                ST_IDLE: if (go) begin
                    ch_q      <= arb_idx;
                    gnt_q     <= arb_gnt;
                    addr_q    <= slot_addr(arb_idx, bus.rewind ? PW'(0) : ptr_q[arb_idx]);
                    rewound_q <= 1'b0;
                end
                ST_WAIT: begin
                    link_q[slot_lsb(ch_q) +: DW] <= bus.mem_rdata;
                    avail_q                      <= gnt_q;
                end
                ST_DELIVER: begin
                    if (!rewound_q) ptr_q[ch_q] <= ptr_q[ch_q] + 1'b1;
                    rr_q <= (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                end
                default: ;
            endcase
            // Rewind wins over the in-flight increment, including one still pending.
            if (bus.rewind) begin
                for (int i = 0; i < N_CH; i++) ptr_q[i] <= '0;
                if (state_q != ST_IDLE) rewound_q <= 1'b1;
            end
        end
    end

    assign bus.mem_addr           = addr_q;
    assign bus.mem_rd_en          = (state_q == ST_GRANT);
    assign bus.metadata_link      = link_q;
    assign bus.metadata_available = avail_q;
    assign bus.busy               = (state_q != ST_IDLE);
    assign bus.state              = state_q;
endmodule

// File: tb/tb_metadata_server.sv
// Testbench for metadata_server: vector table, directed corner sequences and a random run against a transaction model.
module tb_metadata_server;
    import metadata_server_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    metadata_server_if bus();
    metadata_server dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference model
    int              mptr [N_CH];
    int              mrr;
    logic [DW-1:0]   mslot [N_CH];
    logic [N_CH-1:0] prev_req, prev_avail, last_avail;
    logic            exp_grant, inflight, supp;
    int              age, cur_ch, pick, cidx, nbad, n_deliv;
    logic [DW-1:0]   cur_data;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            mptr[i]  = 0;
            mslot[i] = '0;
        end
        mrr = 0; exp_grant = 1'b0; inflight = 1'b0; supp = 1'b0; age = -1;
    endtask

    always @(negedge clk) begin
        last_avail = bus.metadata_available;
        if (reset) begin
            model_reset();
        end else begin
            check("grant_timing", 64'(bus.mem_rd_en), 64'(exp_grant));
            if (bus.mem_rd_en) begin
                pick = -1;
                for (int k = 0; k < N_CH; k++) begin
                    cidx = (mrr + k) % N_CH;
                    if (pick < 0 && prev_req[cidx] && !prev_avail[cidx]) pick = cidx;
                end
                if (pick < 0) pick = 0;
                check("grant_addr", 64'(bus.mem_addr), 64'(pick * CH_DEPTH + mptr[pick]));
                cur_ch   = pick;
                cur_data = mem[pick * CH_DEPTH + mptr[pick]];
                age = 0; inflight = 1'b1; supp = 1'b0;
            end else if (age >= 0) begin
                age++;
            end
            check("avail", 64'(bus.metadata_available), (age == 2) ? (64'(1) << cur_ch) : 64'(0));
            if (age == 2) begin
                mslot[cur_ch] = cur_data;
                nbad = 0;
                for (int i = 0; i < N_CH; i++)
                    if (bus.metadata_link[i*DW +: DW] !== mslot[i]) nbad++;
                check("link_slots_bad", 64'(nbad), 64'(0));
                if (!supp && !bus.rewind) mptr[cur_ch] = (mptr[cur_ch] + 1) % CH_DEPTH;
                mrr = (cur_ch + 1) % N_CH;
                inflight = 1'b0; age = -1; n_deliv++;
            end
            if (bus.rewind) begin
                for (int i = 0; i < N_CH; i++) mptr[i] = 0;
                if (inflight) supp = 1'b1;
            end
            exp_grant = !inflight && (bus.metadata_available == '0) && bus.load_done &&
                        !bus.pause && (bus.metadata_request != '0);
        end
        prev_req   = bus.metadata_request;
        prev_avail = bus.metadata_available;
    end

    // Driver / helper tasks
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.load_done = 1'b0; bus.pause = 1'b0; bus.rewind = 1'b0; bus.metadata_request = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_rd_en", 64'(bus.mem_rd_en), 64'(0));
        check("rst_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_avail", 64'(bus.metadata_available), 64'(0));
        check("rst_link_zero", 64'(bus.metadata_link == '0), 64'(1));
    endtask

    task automatic wait_rd(input string nm, output logic [AW-1:0] a);
        bit ok = 1'b0;
        a = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin ok = 1'b1; a = bus.mem_addr; end
        end
        if (!ok) check({nm, "_rd_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_av(input string nm, output logic [N_CH-1:0] av);
        bit ok = 1'b0;
        av = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (bus.metadata_available != '0) begin ok = 1'b1; av = bus.metadata_available; end
        end
        if (!ok) check({nm, "_av_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic count_rd(input int ncyc, output int cnt);
        cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) cnt++;
        end
    endtask

    typedef struct {
        int            ch;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs [4];

    logic [AW-1:0]   a;
    logic [N_CH-1:0] av;
    int              cnt;

    initial begin
        reset = 1'b1;
        bus.load_done = 1'b0; bus.pause = 1'b0; bus.rewind = 1'b0; bus.metadata_request = '0;
        n_deliv = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i) ^ 16'h3C00;
        mem[0] = 16'hA5A5;

        vecs[0] = '{ch: 0,  exp_addr: 14'd0,    exp_data: 16'hA5A5};
        vecs[1] = '{ch: 3,  exp_addr: 14'd768,  exp_data: 16'h3F00};
        vecs[2] = '{ch: 36, exp_addr: 14'd9216, exp_data: 16'h1800};
        vecs[3] = '{ch: 5,  exp_addr: 14'd1280, exp_data: 16'h3900};

        // Single-word latency from reset: rd_en at T+1, available at T+3
        for (int v = 0; v < 4; v++) begin
            do_reset();
            @(posedge clk); #1;
            bus.load_done = 1'b1;
            bus.metadata_request[vecs[v].ch] = 1'b1;
            @(negedge clk);
            check("vec_t0_rd_en", 64'(bus.mem_rd_en), 64'(0));
            @(negedge clk);
            check("vec_t1_rd_en", 64'(bus.mem_rd_en), 64'(1));
            check("vec_t1_addr", 64'(bus.mem_addr), 64'(vecs[v].exp_addr));
            @(negedge clk);
            check("vec_t2_busy", 64'(bus.busy), 64'(1));
            check("vec_t2_avail", 64'(bus.metadata_available), 64'(0));
            @(negedge clk);
            check("vec_t3_avail", 64'(bus.metadata_available), 64'(1) << vecs[v].ch);
            check("vec_t3_slot", 64'(bus.metadata_link[vecs[v].ch*DW +: DW]), 64'(vecs[v].exp_data));
            @(posedge clk); #1;
            bus.metadata_request = '0;
        end

        // Channel 0 held high: second word from address 1
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[0] = 1'b1;
        wait_rd("ch0_w0", a);
        check("ch0_first_addr", 64'(a), 64'(0));
        wait_rd("ch0_w1", a);
        check("ch0_second_addr", 64'(a), 64'(1));
        wait_av("ch0_w1", av);
        @(posedge clk); #1;
        bus.metadata_request = '0;

        // Simultaneous requests 3 and 36 with rr=0
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[3] = 1'b1; bus.metadata_request[36] = 1'b1;
        wait_rd("rr_first", a);
        check("rr_first_addr", 64'(a), 64'(768));
        wait_av("rr_first", av);
        check("rr_first_avail", 64'(av), 64'(1) << 3);
        @(posedge clk); #1;
        bus.metadata_request[3] = 1'b0;
        wait_rd("rr_second", a);
        check("rr_second_addr", 64'(a), 64'(9216));
        wait_av("rr_second", av);
        @(posedge clk); #1;
        bus.metadata_request[36] = 1'b0;
        count_rd(12, cnt);
        check("rr_no_double", 64'(cnt), 64'(0));

        // Channel 5 pointer wrap after CH_DEPTH reads
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[5] = 1'b1;
        for (int k = 0; k <= CH_DEPTH; k++) begin
            wait_rd("wrap", a);
            if (k == CH_DEPTH - 1) check("wrap_last_addr", 64'(a), 64'(1280 + CH_DEPTH - 1));
            if (k == CH_DEPTH)     check("wrap_addr", 64'(a), 64'(1280));
        end
        wait_av("wrap", av);
        @(posedge clk); #1;
        bus.metadata_request = '0;

        // Pause raised one cycle after GRANT on channel 2
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[2] = 1'b1;
        wait_rd("pause", a);
        @(posedge clk); #1;
        bus.pause = 1'b1; bus.metadata_request[4] = 1'b1;
        wait_av("pause", av);
        check("pause_inflight_avail", 64'(av), 64'(1) << 2);
        @(posedge clk); #1;
        bus.metadata_request[2] = 1'b0;
        count_rd(12, cnt);
        check("pause_no_grant", 64'(cnt), 64'(0));
        @(posedge clk); #1;
        bus.pause = 1'b0;
        wait_rd("unpause", a);
        check("unpause_addr", 64'(a), 64'(4 * CH_DEPTH));
        wait_av("unpause", av);
        @(posedge clk); #1;
        bus.metadata_request = '0;

        // Rewind during WAIT after channel 1 reached ptr 10
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[1] = 1'b1;
        for (int k = 0; k < 10; k++) wait_av("rew_fill", av);
        wait_rd("rew", a);
        check("rew_pre_addr", 64'(a), 64'(256 + 10));
        @(posedge clk); #1;
        bus.rewind = 1'b1;
        @(posedge clk); #1;
        bus.rewind = 1'b0;
        @(negedge clk);
        check("rew_avail", 64'(bus.metadata_available), 64'(1) << 1);
        check("rew_slot", 64'(bus.metadata_link[1*DW +: DW]), 64'(16'h3D0A));
        wait_rd("rew_next", a);
        check("rew_next_addr", 64'(a), 64'(256));
        wait_av("rew_next", av);
        @(posedge clk); #1;
        bus.metadata_request = '0;

        // Reset asserted during WAIT
        do_reset();
        @(posedge clk); #1;
        bus.load_done = 1'b1; bus.metadata_request[7] = 1'b1;
        wait_rd("rstw", a);
        @(posedge clk); #1;
        reset = 1'b1; bus.metadata_request = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstw_avail", 64'(bus.metadata_available), 64'(0));
        check("rstw_busy", 64'(bus.busy), 64'(0));
        check("rstw_link_zero", 64'(bus.metadata_link == '0), 64'(1));

        // Random consumers, pause, load_done and rewind against the model
        do_reset();
        n_deliv = 0;
        @(posedge clk); #1;
        bus.load_done = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N_CH; i++) begin
                if (last_avail[i])                     bus.metadata_request[i] = ($urandom_range(0, 3) == 0);
                else if (!bus.metadata_request[i] &&
                         $urandom_range(0, 15) == 0)   bus.metadata_request[i] = 1'b1;
            end
            if ($urandom_range(0, 19) == 0)  bus.pause = ~bus.pause;
            if ($urandom_range(0, 299) == 0) bus.load_done = ~bus.load_done;
            bus.rewind = ($urandom_range(0, 199) == 0);
        end
        bus.pause = 1'b0; bus.load_done = 1'b1; bus.rewind = 1'b0;
        for (int cyc = 0; cyc < 3000 && bus.metadata_request != '0; cyc++) begin
            @(posedge clk); #1;
            bus.metadata_request = bus.metadata_request & ~last_avail;
        end
        check("random_drained", 64'(bus.metadata_request == '0), 64'(1));
        check("random_progress", 64'(n_deliv > 100), 64'(1));
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
